mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the MIPS pipeline. Sits between the X/M pipeline register and the m-w register, and directly drives the m-w inputs.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake, and stalls upstream while a request is outstanding.
- Aligns load data to byte, half or word, with sign or zero extension, and generates store byte enables.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN).
- ADDR_W, 32, address width; data width is fixed at 32.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  upstream instruction valid
- pc_in  in  32  instruction PC
- instr_in  in  32  instruction word
- alu_result_in  in  32  effective address, or ALU result for non-memory ops
- store_data_in  in  32  rt value for stores
- mem_read_in  in  1  load op
- mem_write_in  in  1  store op
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_in  in  1  zero-extend load (LBU/LHU)
- wb_enable_in  in  1  register writeback requested
- stall_out  out  1  upstream must hold its outputs
- valid_out  out  1  outputs below valid this cycle
- pc_out, instr_out  out  32  to m-w
- mem_data_out  out  32  aligned/extended load data; 0 otherwise
- mem_address_out  out  32  alu_result passthrough
- mem_op_out  out  1  1 if a load produced mem_data_out
- wb_enable_out  out  1  to m-w; forced 0 on error
- addr_error_out  out  1  misaligned access (or timeout)
- dmem_req  out  1  request valid
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  request complete

Behaviour:
- Interface: single clock `clock`; synchronous active-high `reset`.
- Reset: state IDLE; every output 0, including stall_out and dmem_req.
- FSM has two states, IDLE and WAIT.
- IDLE, valid_in=0: valid_out=0 next cycle (bubble).
- IDLE, valid_in with no memory op: registered passthrough. valid_out=1 next cycle, mem_data_out=0, mem_op_out=0.
- IDLE, valid_in with a memory op, misaligned: misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued.
  - Next cycle: valid_out=1, addr_error_out=1, wb_enable_out=0.
- IDLE, valid_in with a memory op, aligned:
  - Latch instruction fields.
  - Next cycle: dmem_req=1 with addr/we/be/wdata. Enter WAIT.
- WAIT:
  - stall_out=1 (registered: stall_out == state is WAIT). valid_out=0.
  - dmem_* held stable until dmem_ack is sampled high.
  - On ack: dmem_req=0 next cycle, state returns to IDLE, valid_out=1 next cycle.
  - For loads, mem_data_out is the formatted dmem_rdata and mem_op_out=1.
- Upstream advances on the accept cycle; its next instruction is held by stall_out and accepted on the first IDLE cycle.
- Load latency: accept at N, req at N+1, ack at K ≥ N+1, valid_out at K+1.
- dmem_ack is ignored in IDLE.
- Little-endian lanes: addr[1:0]=0 selects bits 7:0.
  - Byte: be = 1<<addr[1:0], wdata = {4{sd[7:0]}}.
  - Half: be = 0011 or 1100, wdata = {2{sd[15:0]}}.
  - Word: be = 1111.
- Load extension: sign-extend from bit 7 or 15 unless mem_unsigned_in.
- Store: mem_data_out=0, mem_op_out=0, wb_enable_out passed through (normally 0).
- Reset during WAIT: dmem_req drops next edge; a late ack is ignored; no valid_out.
- mem_read_in and mem_write_in both set: treated as store.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without ack: drop dmem_req, return to IDLE, valid_out=1 with addr_error_out=1 and wb_enable_out=0.
  - Ack arriving on the same cycle as expiry wins.
- Undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Package mem_stage_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings ST_IDLE/ST_WAIT;
  - DATA_W=32.
- Sub-module mem_lane_align, combinational:
  - store be/wdata generation;
  - load lane extract and extension;
  - misalign detect.

Test Plan:
- add, valid_in=1, alu_result=0x1234 → next cycle valid_out=1, mem_address_out=0x1234, mem_data_out=0, stall_out=0.
- LB at 0x1003, rdata=0x80FF_FF00, ack after 3 cycles → stall_out high 3 cycles, dmem_addr=0x1000, mem_data_out=0xFFFF_FF80.
  - Same with mem_unsigned_in=1 → 0x0000_0080.
- SH at 0x2002, store_data=0xAAAA_BEEF → dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, held until ack.
- LW at 0x3002 → no dmem_req; valid_out=1, addr_error_out=1, wb_enable_out=0 next cycle.
- Reset asserted mid-WAIT, then ack pulse → dmem_req=0 after reset edge, valid_out stays 0, state IDLE.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never given → abort after 16 WAIT cycles with addr_error_out=1, then next instruction accepted.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage.
// Optional timeout feature is selected with MEM_TIMEOUT_EN.
package mem_stage_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: store enables/data,
// load extraction with sign/zero extension, misalign detect.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Size 2'b11 falls into the word branch.
    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        o_misalign  = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = i_unsigned ? {24'd0, w_byte}
                                         : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = i_unsigned ? {16'd0, w_half}
                                         : {{16{w_half[15]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            default: begin
                o_misalign  = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ack handshake and stalls upstream.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES WAIT cycles.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic              wb_enable_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       instr_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_address_out,
    output logic              mem_op_out,
    output logic              wb_enable_out,
    output logic              addr_error_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    mem_state_e        r_state, w_nx_state;
    logic              r_valid, w_nx_valid;
    logic [31:0]       r_pc, w_nx_pc;
    logic [31:0]       r_instr, w_nx_instr;
    logic [ADDR_W-1:0] r_addr, w_nx_addr;
    logic [DATA_W-1:0] r_data, w_nx_data;
    logic              r_op, w_nx_op;
    logic              r_wb, w_nx_wb;
    logic              r_err, w_nx_err;
    logic              r_req, w_nx_req;
    logic              r_we, w_nx_we;
    logic [3:0]        r_be, w_nx_be;
    logic [DATA_W-1:0] r_wdata, w_nx_wdata;
    logic              r_load, w_nx_load;
    logic [1:0]        r_size, w_nx_size;
    logic              r_uns, w_nx_uns;

    logic              w_in_wait;
    logic              w_mem_op;
    logic [1:0]        w_lo;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_data;
    logic              w_misalign;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_nx_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // In IDLE the aligner sees the incoming op; in WAIT the latched load.
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_mem_op  = mem_read_in | mem_write_in;
    assign w_lo      = w_in_wait ? r_addr[1:0] : alu_result_in[1:0];
    assign w_size    = w_in_wait ? r_size : mem_size_in;
    assign w_uns     = w_in_wait ? r_uns : mem_unsigned_in;

    mem_lane_align u_align (
        .i_addr_lo    (w_lo),
        .i_size       (w_size),
        .i_unsigned   (w_uns),
        .i_store_data (store_data_in),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    // Next-state and next-output decode; valid_out is a one-cycle pulse.
    always_comb begin
        w_nx_state = r_state;
        w_nx_valid = 1'b0;
        w_nx_pc    = r_pc;
        w_nx_instr = r_instr;
        w_nx_addr  = r_addr;
        w_nx_data  = r_data;
        w_nx_op    = r_op;
        w_nx_wb    = r_wb;
        w_nx_err   = r_err;
        w_nx_req   = r_req;
        w_nx_we    = r_we;
        w_nx_be    = r_be;
        w_nx_wdata = r_wdata;
        w_nx_load  = r_load;
        w_nx_size  = r_size;
        w_nx_uns   = r_uns;
`ifdef MEM_TIMEOUT_EN
        w_nx_cnt   = r_cnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                w_nx_req = 1'b0;
                if (valid_in) begin
                    w_nx_pc    = pc_in;
                    w_nx_instr = instr_in;
                    w_nx_addr  = alu_result_in;
                    w_nx_wb    = wb_enable_in;
                    w_nx_size  = mem_size_in;
                    w_nx_uns   = mem_unsigned_in;
                    w_nx_load  = mem_read_in & ~mem_write_in;
                    w_nx_data  = '0;
                    w_nx_op    = 1'b0;
                    w_nx_err   = 1'b0;
                    if (!w_mem_op) begin
                        w_nx_valid = 1'b1;
                    end else if (w_misalign) begin
                        w_nx_valid = 1'b1;
                        w_nx_err   = 1'b1;
                        w_nx_wb    = 1'b0;
                    end else begin
                        w_nx_state = ST_WAIT;
                        w_nx_req   = 1'b1;
                        w_nx_we    = mem_write_in;
                        w_nx_be    = w_be;
                        w_nx_wdata = w_wdata;
`ifdef MEM_TIMEOUT_EN
                        w_nx_cnt   = '0;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    w_nx_state = ST_IDLE;
                    w_nx_req   = 1'b0;
                    w_nx_valid = 1'b1;
                    if (r_load) begin
                        w_nx_data = w_load_data;
                        w_nx_op   = 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_nx_state = ST_IDLE;
                    w_nx_req   = 1'b0;
                    w_nx_valid = 1'b1;
                    w_nx_err   = 1'b1;
                    w_nx_wb    = 1'b0;
                end else begin
                    w_nx_cnt   = r_cnt + 1'b1;
`endif
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_op    <= 1'b0;
            r_wb    <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_load  <= 1'b0;
            r_size  <= '0;
            r_uns   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_nx_state;
            r_valid <= w_nx_valid;
            r_pc    <= w_nx_pc;
            r_instr <= w_nx_instr;
            r_addr  <= w_nx_addr;
            r_data  <= w_nx_data;
            r_op    <= w_nx_op;
            r_wb    <= w_nx_wb;
            r_err   <= w_nx_err;
            r_req   <= w_nx_req;
            r_we    <= w_nx_we;
            r_be    <= w_nx_be;
            r_wdata <= w_nx_wdata;
            r_load  <= w_nx_load;
            r_size  <= w_nx_size;
            r_uns   <= w_nx_uns;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= w_nx_cnt;
`endif
        end
    end

    assign stall_out       = w_in_wait;
    assign valid_out       = r_valid;
    assign pc_out          = r_pc;
    assign instr_out       = r_instr;
    assign mem_data_out    = r_data;
    assign mem_address_out = r_addr;
    assign mem_op_out      = r_op;
    assign wb_enable_out   = r_wb;
    assign addr_error_out  = r_err;
    assign dmem_req        = r_req;
    assign dmem_we         = r_we;
    assign dmem_addr       = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_be         = r_be;
    assign dmem_wdata      = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table,
// random transactions against a lane model, and handshake corner cases.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in, instr_in, alu_result_in, store_data_in;
    logic        mem_read_in, mem_write_in, mem_unsigned_in, wb_enable_in;
    logic [1:0]  mem_size_in;
    logic        stall_out, valid_out, mem_op_out, wb_enable_out;
    logic        addr_error_out, dmem_req, dmem_we, dmem_ack;
    logic [31:0] pc_out, instr_out, mem_data_out, mem_address_out;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_pc, cur_instr;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        rd, wr, uns, wb;
        logic [31:0] sd, rdata;
        int          lat;
        logic        e_req, e_err, e_op, e_wb;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_daddr;
    } vec_t;

    mem_access_stage dut (
        .clock           (clock),
        .reset           (reset),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .instr_in        (instr_in),
        .alu_result_in   (alu_result_in),
        .store_data_in   (store_data_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .mem_size_in     (mem_size_in),
        .mem_unsigned_in (mem_unsigned_in),
        .wb_enable_in    (wb_enable_in),
        .stall_out       (stall_out),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instr_out       (instr_out),
        .mem_data_out    (mem_data_out),
        .mem_address_out (mem_address_out),
        .mem_op_out      (mem_op_out),
        .wb_enable_out   (wb_enable_out),
        .addr_error_out  (addr_error_out),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [1:0] size,
        input logic rd, input logic wr, input logic uns, input logic wb,
        input logic [31:0] sd, input logic [31:0] rdata, input int lat,
        input logic e_req, input logic e_err, input logic e_op,
        input logic e_wb, input logic [31:0] e_data, input logic [3:0] e_be,
        input logic [31:0] e_wdata, input logic [31:0] e_daddr);
        vec_t v;
        v.addr = addr; v.size = size; v.rd = rd; v.wr = wr;
        v.uns = uns; v.wb = wb; v.sd = sd; v.rdata = rdata; v.lat = lat;
        v.e_req = e_req; v.e_err = e_err; v.e_op = e_op; v.e_wb = e_wb;
        v.e_data = e_data; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_daddr = e_daddr;
        return v;
    endfunction

    // Reference: lanes computed from byte counts and shifts.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int lo = int'(v.addr[1:0]);
        int nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        bit st = v.wr;
        bit ld = v.rd && !v.wr;
        bit mis = (ld || st) && ((lo % nb) != 0);
        longint mask = (64'd1 << (8 * nb)) - 1;
        logic [31:0] val;
        r.e_req = (ld || st) && !mis;
        r.e_err = mis;
        r.e_wb = mis ? 1'b0 : v.wb;
        r.e_op = ld && !mis;
        r.e_daddr = v.addr - lo;
        r.e_be = 4'd0;
        r.e_wdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (!mis && k >= lo && k < lo + nb) r.e_be[k] = 1'b1;
            r.e_wdata[8*k +: 8] = v.sd[8*(k % nb) +: 8];
        end
        val = 32'(v.rdata >> (8 * lo)) & 32'(mask);
        if (!v.uns && val[8*nb-1]) val = val | ~32'(mask);
        r.e_data = r.e_op ? val : 32'd0;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        cur_pc = $urandom;
        cur_instr = $urandom;
        valid_in = 1'b1;
        pc_in = cur_pc;
        instr_in = cur_instr;
        alu_result_in = v.addr;
        store_data_in = v.sd;
        mem_read_in = v.rd;
        mem_write_in = v.wr;
        mem_size_in = v.size;
        mem_unsigned_in = v.uns;
        wb_enable_in = v.wb;
    endtask

    task automatic run(input string tag, input vec_t v);
        int n = 0;
        int bad = 0;
        drive(v);
        chk({tag, ".idle"}, stall_out, 0);
        @(posedge clock); #1;
        valid_in = 1'b0;
        if (v.e_req) begin
            chk({tag, ".req"}, dmem_req, 1);
            chk({tag, ".we"}, dmem_we, v.wr);
            chk({tag, ".daddr"}, dmem_addr, v.e_daddr);
            if (v.wr) begin
                chk({tag, ".be"}, dmem_be, v.e_be);
                chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
            end
            for (int i = 0; i < v.lat; i++) begin
                if (stall_out && dmem_req && !valid_out) n++;
                if (dmem_addr !== v.e_daddr) bad++;
                if (v.wr && dmem_wdata !== v.e_wdata) bad++;
                if (i == v.lat - 1) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(posedge clock); #1;
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            chk({tag, ".stallcyc"}, n, v.lat);
            chk({tag, ".held"}, bad, 0);
        end else begin
            chk({tag, ".noreq"}, dmem_req, 0);
        end
        chk({tag, ".valid"}, valid_out, 1);
        chk({tag, ".data"}, mem_data_out, v.e_data);
        chk({tag, ".op"}, mem_op_out, v.e_op);
        chk({tag, ".err"}, addr_error_out, v.e_err);
        chk({tag, ".wb"}, wb_enable_out, v.e_wb);
        chk({tag, ".reqoff"}, dmem_req, 0);
        chk({tag, ".stall"}, stall_out, 0);
        chk({tag, ".maddr"}, mem_address_out, v.addr);
        chk({tag, ".pc"}, pc_out, cur_pc);
        chk({tag, ".instr"}, instr_out, cur_instr);
    endtask

    vec_t tbl[13];
    vec_t rv;

    initial begin
        tbl[0]  = mk(32'h1234, 2, 0, 0, 0, 1, 0, 0, 1,
                     0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0);
        tbl[1]  = mk(32'h1003, 0, 1, 0, 0, 1, 0, 32'h80FF_FF00, 3,
                     1, 0, 1, 1, 32'hFFFF_FF80, 4'h0, 32'h0, 32'h1000);
        tbl[2]  = mk(32'h1003, 0, 1, 0, 1, 1, 0, 32'h80FF_FF00, 3,
                     1, 0, 1, 1, 32'h0000_0080, 4'h0, 32'h0, 32'h1000);
        tbl[3]  = mk(32'h2002, 1, 0, 1, 0, 0, 32'hAAAA_BEEF, 0, 2,
                     1, 0, 0, 0, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h2000);
        tbl[4]  = mk(32'h3002, 2, 1, 0, 0, 1, 0, 0, 1,
                     0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        tbl[5]  = mk(32'h4002, 1, 1, 0, 0, 1, 0, 32'h8001_1234, 1,
                     1, 0, 1, 1, 32'hFFFF_8001, 4'h0, 32'h0, 32'h4000);
        tbl[6]  = mk(32'h4000, 1, 1, 0, 1, 1, 0, 32'h8001_F234, 2,
                     1, 0, 1, 1, 32'h0000_F234, 4'h0, 32'h0, 32'h4000);
        tbl[7]  = mk(32'h5001, 0, 0, 1, 0, 0, 32'h1234_5678, 0, 1,
                     1, 0, 0, 0, 32'h0, 4'b0010, 32'h7878_7878, 32'h5000);
        tbl[8]  = mk(32'h6000, 2, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h5555_5555, 2,
                     1, 0, 0, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h6000);
        tbl[9]  = mk(32'h7001, 1, 0, 1, 0, 1, 32'h1111_2222, 0, 1,
                     0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        tbl[10] = mk(32'h8004, 3, 1, 0, 0, 1, 0, 32'hCAFE_F00D, 4,
                     1, 0, 1, 1, 32'hCAFE_F00D, 4'h0, 32'h0, 32'h8004);
        tbl[11] = mk(32'h9000, 0, 1, 0, 0, 1, 0, 32'h0000_007F, 1,
                     1, 0, 1, 1, 32'h0000_007F, 4'h0, 32'h0, 32'h9000);
        tbl[12] = mk(32'h9001, 1, 1, 0, 0, 1, 0, 0, 1,
                     0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);

        reset = 1'b1;
        valid_in = 1'b0;
        pc_in = '0; instr_in = '0; alu_result_in = '0; store_data_in = '0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = '0;
        mem_unsigned_in = 1'b0; wb_enable_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.valid", valid_out, 0);
        chk("rst.stall", stall_out, 0);
        chk("rst.req", dmem_req, 0);
        chk("rst.err", addr_error_out, 0);
        chk("rst.wb", wb_enable_out, 0);
        chk("rst.data", mem_data_out, 0);
        chk("rst.pc", pc_out, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 13; i++)
            run($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            rv = mk($urandom, 2'($urandom_range(0, 3)), op[0], op[1],
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom_range(1, 5),
                    0, 0, 0, 0, 0, 0, 0, 0);
            if (i % 3 == 0) rv.addr[1:0] = 2'b00;
            run($sformatf("rnd%0d", i), model(rv));
        end

        // ack while idle is ignored
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        chk("idleack.valid", valid_out, 0);
        chk("idleack.req", dmem_req, 0);
        chk("idleack.stall", stall_out, 0);

        // reset during WAIT, then a late ack
        drive(mk(32'hA000, 2, 1, 0, 0, 1, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        valid_in = 1'b0;
        chk("rstw.req", dmem_req, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rstw.reqoff", dmem_req, 0);
        chk("rstw.stall", stall_out, 0);
        chk("rstw.valid", valid_out, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        chk("rstw.lateack", valid_out, 0);
        chk("rstw.op", mem_op_out, 0);
        run("rstw.after", tbl[0]);

        // next instruction held by stall and accepted on first IDLE cycle
        drive(mk(32'hB000, 2, 1, 0, 0, 1, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        chk("b2b.stall", stall_out, 1);
        pc_in = 32'h0000_0B0B;
        alu_result_in = 32'h0000_B0B0;
        mem_read_in = 1'b0;
        wb_enable_in = 1'b1;
        @(posedge clock); #1;
        chk("b2b.hold", valid_out, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1122_3344;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        chk("b2b.ldvalid", valid_out, 1);
        chk("b2b.lddata", mem_data_out, 32'h1122_3344);
        chk("b2b.ldaddr", mem_address_out, 32'h0000_B000);
        chk("b2b.stalloff", stall_out, 0);
        @(posedge clock); #1;
        valid_in = 1'b0;
        chk("b2b.addvalid", valid_out, 1);
        chk("b2b.addaddr", mem_address_out, 32'h0000_B0B0);
        chk("b2b.addpc", pc_out, 32'h0000_0B0B);
        chk("b2b.addop", mem_op_out, 0);
        @(posedge clock); #1;
        chk("b2b.bubble", valid_out, 0);

`ifdef MEM_TIMEOUT_EN
        begin
            int n = 0;
            drive(mk(32'hC000, 2, 1, 0, 0, 1, 0, 0, 1,
                     0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clock); #1;
            valid_in = 1'b0;
            while (stall_out && n < 64) begin
                n++;
                @(posedge clock); #1;
            end
            chk("to.cycles", n, 16);
            chk("to.valid", valid_out, 1);
            chk("to.err", addr_error_out, 1);
            chk("to.wb", wb_enable_out, 0);
            chk("to.req", dmem_req, 0);
            run("to.next", tbl[0]);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
